// File: rtl/ysyx_22041071_axi_rd_slave_if.sv
// AR/R read-channel bundle between the IF/MEM read arbiter (master) and the
// read slave. Optional macro YSYX_22041071_AXI_WRAP_EN adds ar_burst.
interface ysyx_22041071_axi_rd_slave_if;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [1:0]  ar_size;
`ifdef YSYX_22041071_AXI_WRAP_EN
  logic [1:0]  ar_burst;
`endif
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [63:0] r_addr;
  logic [1:0]  r_resp;
  logic        r_last;

  modport master (
    output ar_valid, ar_addr, ar_len, ar_size,
`ifdef YSYX_22041071_AXI_WRAP_EN
    output ar_burst,
`endif
    input  ar_ready,
    input  r_valid, r_data, r_addr, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_size,
`ifdef YSYX_22041071_AXI_WRAP_EN
    input  ar_burst,
`endif
    output ar_ready,
    output r_valid, r_data, r_addr, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/ysyx_22041071_axi_rd_slave.sv
// AXI-style read responder: accepts one AR request, walks the burst over a
// 1-cycle-latency synchronous SRAM and returns one R beat per two cycles.
// Out-of-window or misaligned requests answer every beat with SLVERR.
// Optional macro YSYX_22041071_AXI_WRAP_EN adds WRAP bursts via ar_burst.
module ysyx_22041071_axi_rd_slave #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter logic [63:0] MEM_BYTES = 64'h0800_0000,
  parameter int          MEM_AW    = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_22041071_axi_rd_slave_if.slave bus,
  output logic                       mem_en,
  output logic [MEM_AW-1:0]          mem_addr,
  input  logic [63:0]                mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [64:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [64:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES} - 65'd1;

  state_t      state;
  state_t      state_d;

  logic        ar_ready_q;
  logic        r_valid_q;
  logic [63:0] r_addr_q;
  logic [1:0]  r_resp_q;
  logic        r_last_q;
  logic        mem_en_q;
  logic [MEM_AW-1:0] mem_addr_q;

  logic [63:0] cur_addr;
  logic [7:0]  len_q;
  logic [1:0]  size_q;
  logic [7:0]  cnt;
  logic        err_q;
  logic        resp_first;
  logic [63:0] data_hold;
`ifdef YSYX_22041071_AXI_WRAP_EN
  logic [1:0]  burst_q;
  logic [11:0] span_q;
  logic [63:0] wrap_mask;
`endif

  logic        ar_hs;
  logic        r_hs;
  logic        err_calc;
  logic [11:0] span_bytes;
  logic [64:0] win_lo;
  logic [64:0] win_hi;
  logic        misalign;
  logic        len_bad;
  logic [63:0] incr_next;
  logic [63:0] next_addr;

  // Doubleword index of a byte address inside the served window.
  function automatic logic [MEM_AW-1:0] dw_index(input logic [63:0] a);
    dw_index = MEM_AW'((a - BASE_ADDR) >> 3);
  endfunction

  assign ar_hs = bus.ar_valid && ar_ready_q && (state == IDLE);
  assign r_hs  = r_valid_q && bus.r_ready;

  assign bus.ar_ready = ar_ready_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_addr   = r_addr_q;
  assign bus.r_resp   = r_resp_q;
  assign bus.r_last   = r_last_q;
  assign mem_en       = mem_en_q;
  assign mem_addr     = mem_addr_q;

  // SRAM data is only valid in the first RESP cycle, so pass it straight
  // through then and serve the captured copy while the master stalls.
  assign bus.r_data = (state == RESP && !err_q) ? (resp_first ? mem_rdata : data_hold) : 64'd0;

  // Request check: alignment for the beat size and the whole burst footprint inside the window.
  always_comb begin
    span_bytes = ({4'd0, bus.ar_len} + 12'd1) << bus.ar_size;
    misalign   = (bus.ar_addr & ((64'd1 << bus.ar_size) - 64'd1)) != 64'd0;
    len_bad    = 1'b0;
    win_lo     = {1'b0, bus.ar_addr};
`ifdef YSYX_22041071_AXI_WRAP_EN
    if (bus.ar_burst == 2'b10) begin
      win_lo  = {1'b0, bus.ar_addr & ~({52'd0, span_bytes} - 64'd1)};
      len_bad = !(bus.ar_len == 8'd1 || bus.ar_len == 8'd3 ||
                  bus.ar_len == 8'd7 || bus.ar_len == 8'd15);
    end
`endif
    win_hi   = win_lo + {53'd0, span_bytes} - 65'd1;
    err_calc = misalign || len_bad || (win_lo < WIN_LO) || (win_hi > WIN_HI);
  end

  // Address of the following beat; WRAP keeps the upper bits and wraps the low ones.
  always_comb begin
    incr_next = cur_addr + (64'd1 << size_q);
    next_addr = incr_next;
`ifdef YSYX_22041071_AXI_WRAP_EN
    span_q    = ({4'd0, len_q} + 12'd1) << size_q;
    wrap_mask = {52'd0, span_q} - 64'd1;
    if (burst_q == 2'b10) begin
      next_addr = (cur_addr & ~wrap_mask) | (incr_next & wrap_mask);
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic: IDLE -> FETCH on AR, FETCH -> RESP, RESP loops per beat.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (ar_hs) state_d = FETCH;
      FETCH:   state_d = RESP;
      RESP:    if (r_hs) state_d = r_last_q ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Burst context, SRAM strobe and registered R-channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_addr_q   <= 64'd0;
      r_resp_q   <= 2'b00;
      r_last_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      cur_addr   <= 64'd0;
      len_q      <= 8'd0;
      size_q     <= 2'd0;
      cnt        <= 8'd0;
      err_q      <= 1'b0;
      resp_first <= 1'b0;
      data_hold  <= 64'd0;
`ifdef YSYX_22041071_AXI_WRAP_EN
      burst_q    <= 2'b01;
`endif
    end else begin
      mem_en_q   <= 1'b0;
      resp_first <= 1'b0;
      ar_ready_q <= (state == IDLE) && !ar_hs;
      if (resp_first) begin
        data_hold <= mem_rdata;
      end
      case (state)
        IDLE: begin
          if (ar_hs) begin
            cur_addr <= bus.ar_addr;
            len_q    <= bus.ar_len;
            size_q   <= bus.ar_size;
            cnt      <= 8'd0;
            err_q    <= err_calc;
            mem_en_q <= !err_calc;
            if (!err_calc) begin
              mem_addr_q <= dw_index(bus.ar_addr);
            end
`ifdef YSYX_22041071_AXI_WRAP_EN
            burst_q  <= bus.ar_burst;
`endif
          end
        end
        FETCH: begin
          r_valid_q  <= 1'b1;
          r_addr_q   <= cur_addr;
          r_resp_q   <= err_q ? 2'b10 : 2'b00;
          r_last_q   <= (cnt == len_q);
          resp_first <= 1'b1;
        end
        RESP: begin
          if (r_hs) begin
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            if (!r_last_q) begin
              cur_addr <= next_addr;
              cnt      <= cnt + 8'd1;
              mem_en_q <= !err_q;
              if (!err_q) begin
                mem_addr_q <= dw_index(next_addr);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_slave.sv
// Directed self-checking bench for ysyx_22041071_axi_rd_slave with a small
// 1-cycle-latency SRAM model. WRAP checks appear when
// YSYX_22041071_AXI_WRAP_EN is defined.
module tb_ysyx_22041071_axi_rd_slave;

  logic        clk;
  logic        rst_n;
  logic        mem_en;
  logic [23:0] mem_addr;
  logic [63:0] mem_rdata;
  logic [63:0] mem [256];

  int vectors;
  int miscompares;

  ysyx_22041071_axi_rd_slave_if bus ();

  ysyx_22041071_axi_rd_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] memWord(input logic [23:0] idx);
    memWord = (idx < 24'd256) ? mem[idx[7:0]] : 64'd0;
  endfunction

  // SRAM model: data appears the cycle after mem_en, garbage otherwise.
  always @(posedge clk) begin
    mem_rdata <= mem_en ? memWord(mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // Hard stop in case the sequence ever wedges.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [63:0] exp_data, input logic [63:0] exp_addr,
                           input logic [1:0] exp_resp, input logic exp_last);
    checkOutput({tag, ".r_valid"}, 64'(bus.r_valid), 64'd1);
    checkOutput({tag, ".r_data"},  bus.r_data, exp_data);
    checkOutput({tag, ".r_addr"},  bus.r_addr, exp_addr);
    checkOutput({tag, ".r_resp"},  64'(bus.r_resp), 64'(exp_resp));
    checkOutput({tag, ".r_last"},  64'(bus.r_last), 64'(exp_last));
  endtask

  // Present an AR request and return in the cycle after its handshake.
  task automatic applyStimulus(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] size);
    int budget;
    budget       = 0;
    bus.ar_addr  = addr;
    bus.ar_len   = len;
    bus.ar_size  = size;
    bus.ar_valid = 1'b1;
    while (!bus.ar_ready && budget < 20) begin
      tick();
      budget++;
    end
    checkOutput("ar_ready_wait", 64'(bus.ar_ready), 64'd1);
    tick();
    bus.ar_valid = 1'b0;
  endtask

  // Run a whole burst; optionally stall one beat for five cycles with a stray AR present.
  task automatic runBurst(input string tag, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] size, input logic exp_err, input int stall_beat);
    logic [63:0] exp_addr;
    logic [63:0] exp_data;
    logic [23:0] idx;
    applyStimulus(addr, len, size);
    exp_addr = addr;
    for (int b = 0; b <= int'(len); b++) begin
      idx      = 24'((exp_addr - 64'h8000_0000) >> 3);
      exp_data = exp_err ? 64'd0 : memWord(idx);
      checkOutput({tag, ".mem_en"}, 64'(mem_en), 64'(!exp_err));
      if (!exp_err) checkOutput({tag, ".mem_addr"}, 64'(mem_addr), 64'(idx));
      tick();
      if (b == stall_beat) begin
        bus.r_ready  = 1'b0;
        bus.ar_valid = 1'b1;
        bus.ar_addr  = 64'h8000_0100;
        for (int s = 0; s < 5; s++) begin
          checkBeat({tag, ".stall"}, exp_data, exp_addr, exp_err ? 2'b10 : 2'b00, b == int'(len));
          checkOutput({tag, ".stall_mem_en"}, 64'(mem_en), 64'd0);
          checkOutput({tag, ".stall_ar_ready"}, 64'(bus.ar_ready), 64'd0);
          tick();
        end
        bus.r_ready  = 1'b1;
        bus.ar_valid = 1'b0;
      end
      checkBeat(tag, exp_data, exp_addr, exp_err ? 2'b10 : 2'b00, b == int'(len));
      tick();
      exp_addr = exp_addr + (64'd1 << size);
    end
    checkOutput({tag, ".r_valid_end"}, 64'(bus.r_valid), 64'd0);
  endtask

`ifdef YSYX_22041071_AXI_WRAP_EN
  logic [63:0] wrap_addrs [4] = '{64'h8000_0018, 64'h8000_0000, 64'h8000_0008, 64'h8000_0010};
`endif

  initial begin
    vectors      = 0;
    miscompares  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
    mem[2]       = 64'hDEAD_BEEF_0123_4567;
    rst_n        = 1'b0;
    bus.ar_valid = 1'b0;
    bus.ar_addr  = 64'd0;
    bus.ar_len   = 8'd0;
    bus.ar_size  = 2'd0;
    bus.r_ready  = 1'b1;
`ifdef YSYX_22041071_AXI_WRAP_EN
    bus.ar_burst = 2'b01;
`endif
    $display("[TB] reset values");
    #2;
    checkOutput("rst.ar_ready", 64'(bus.ar_ready), 64'd0);
    checkOutput("rst.r_valid",  64'(bus.r_valid),  64'd0);
    checkOutput("rst.r_data",   bus.r_data,        64'd0);
    checkOutput("rst.r_addr",   bus.r_addr,        64'd0);
    checkOutput("rst.r_resp",   64'(bus.r_resp),   64'd0);
    checkOutput("rst.r_last",   64'(bus.r_last),   64'd0);
    checkOutput("rst.mem_en",   64'(mem_en),       64'd0);
    checkOutput("rst.mem_addr", 64'(mem_addr),     64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rel.ar_ready", 64'(bus.ar_ready), 64'd1);

    $display("[TB] single read with cycle timing");
    applyStimulus(64'h8000_0010, 8'd0, 2'd3);
    checkOutput("single.mem_en",   64'(mem_en),   64'd1);
    checkOutput("single.mem_addr", 64'(mem_addr), 64'd2);
    tick();
    checkBeat("single", 64'hDEAD_BEEF_0123_4567, 64'h8000_0010, 2'b00, 1'b1);
    tick();
    checkOutput("single.t3_r_valid",  64'(bus.r_valid),  64'd0);
    checkOutput("single.t3_ar_ready", 64'(bus.ar_ready), 64'd0);
    tick();
    checkOutput("single.t4_ar_ready", 64'(bus.ar_ready), 64'd1);

    $display("[TB] bursts");
    runBurst("incr4",     64'h8000_0000, 8'd3, 2'd3, 1'b0, -1);
    runBurst("stall",     64'h8000_0008, 8'd1, 2'd3, 1'b0, 0);
    runBurst("half",      64'h8000_0012, 8'd2, 2'd1, 1'b0, -1);
    runBurst("word_ok",   64'h8000_0004, 8'd0, 2'd2, 1'b0, -1);
    runBurst("win_end",   64'h87FF_FFF8, 8'd0, 2'd3, 1'b0, -1);

    $display("[TB] error responses");
    runBurst("below",     64'h7FFF_FFF8, 8'd1, 2'd3, 1'b1, 1);
    runBurst("misalign",  64'h8000_0004, 8'd0, 2'd3, 1'b1, -1);
    runBurst("past_end",  64'h87FF_FFF8, 8'd1, 2'd3, 1'b1, -1);

    $display("[TB] mid-burst reset");
    applyStimulus(64'h8000_0000, 8'd7, 2'd3);
    tick();
    tick();
    tick();
    checkOutput("midrst.pre_r_valid", 64'(bus.r_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.r_valid",  64'(bus.r_valid),  64'd0);
    checkOutput("midrst.r_last",   64'(bus.r_last),   64'd0);
    checkOutput("midrst.r_addr",   bus.r_addr,        64'd0);
    checkOutput("midrst.ar_ready", 64'(bus.ar_ready), 64'd0);
    checkOutput("midrst.mem_en",   64'(mem_en),       64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("midrst.ar_ready_after", 64'(bus.ar_ready), 64'd1);
    runBurst("after_rst", 64'h8000_0010, 8'd0, 2'd3, 1'b0, -1);

`ifdef YSYX_22041071_AXI_WRAP_EN
    $display("[TB] wrap bursts");
    bus.ar_burst = 2'b10;
    applyStimulus(64'h8000_0018, 8'd3, 2'd3);
    for (int b = 0; b < 4; b++) begin
      checkOutput("wrap.mem_en",   64'(mem_en),   64'd1);
      checkOutput("wrap.mem_addr", 64'(mem_addr), (wrap_addrs[b] - 64'h8000_0000) >> 3);
      tick();
      checkBeat("wrap", memWord(24'((wrap_addrs[b] - 64'h8000_0000) >> 3)), wrap_addrs[b], 2'b00, b == 3);
      tick();
    end
    applyStimulus(64'h8000_0000, 8'd2, 2'd3);
    for (int b = 0; b < 3; b++) begin
      checkOutput("wrap_badlen.mem_en", 64'(mem_en), 64'd0);
      tick();
      checkOutput("wrap_badlen.r_valid", 64'(bus.r_valid), 64'd1);
      checkOutput("wrap_badlen.r_resp",  64'(bus.r_resp),  64'd2);
      checkOutput("wrap_badlen.r_data",  bus.r_data,       64'd0);
      checkOutput("wrap_badlen.r_last",  64'(bus.r_last),  64'(b == 2));
      tick();
    end
    bus.ar_burst = 2'b01;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
